// File: rtl/sc_pkg.sv
// Shared widths, thresholds and the grid classification type for the grid monitor.
package sc_pkg;

   localparam int W        = 12;
   localparam int AVG_LOG2 = 3;
   localparam int DEBOUNCE = 4;

   localparam int V_NOM_LO = 3400;
   localparam int V_NOM_HI = 3800;
   localparam int V_FLT_LO = 3000;
   localparam int V_FLT_HI = 4100;
   localparam int F_NOM_LO = 1990;
   localparam int F_NOM_HI = 2010;
   localparam int F_FLT_LO = 1950;
   localparam int F_FLT_HI = 2050;
   localparam int HYST     = 20;

   // The frequency nominal band is only 20 codes wide, so a full HYST shrink
   // would leave it empty; it gets the same fraction of its band as voltage.
   localparam int F_HYST = HYST * (F_NOM_HI - F_NOM_LO) / (V_NOM_HI - V_NOM_LO);

   typedef enum logic [1:0] {
      GRID_NORMAL   = 2'd0,
      GRID_UNSTABLE = 2'd1,
      GRID_FAULT    = 2'd2
   } grid_state_t;

   function automatic logic in_band(input logic [W-1:0] x, input int lo, input int hi);
      return (int'(x) >= lo) && (int'(x) <= hi);
   endfunction

endpackage

// File: rtl/sc_grid_monitor_if.sv
// Sample input and classification output bundle of the grid monitor.
interface sc_grid_monitor_if;
   import sc_pkg::*;

   logic              sample_valid;
   logic [W-1:0]      v_sample;
   logic [W-1:0]      f_sample;
   logic              monitor_clear;
   grid_state_t       grid_state;
   logic              state_change;
   logic              avg_valid;
   logic [W-1:0]      v_avg;
   logic [W-1:0]      f_avg;
   logic [7:0]        fault_count;

   modport master (
      output sample_valid, v_sample, f_sample, monitor_clear,
      input  grid_state, state_change, avg_valid, v_avg, f_avg, fault_count
   );

   modport slave (
      input  sample_valid, v_sample, f_sample, monitor_clear,
      output grid_state, state_change, avg_valid, v_avg, f_avg, fault_count
   );

endinterface

// File: rtl/sc_moving_avg.sv
// Power-of-two window moving average: ring buffer, running sum and fill counter.
module sc_moving_avg #(
   parameter int W        = 12,
   parameter int AVG_LOG2 = 3
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         sample_valid,
   input  logic [W-1:0] sample,
   output logic [W-1:0] avg,
   output logic         avg_valid
);

   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = W + AVG_LOG2;
   localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(N);

   logic [W-1:0]        ring [N];
   logic [AVG_LOG2-1:0] wr_ptr;
   logic [AVG_LOG2:0]   fill;
   logic [SW-1:0]       sum;

   // Cleared ring entries read as zero, so the sum is exact during fill too.
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         for (int i = 0; i < N; i++) ring[i] <= '0;
         wr_ptr <= '0;
         fill   <= '0;
         sum    <= '0;
      end else if (sample_valid) begin
         ring[wr_ptr] <= sample;
         sum          <= sum + SW'(sample) - SW'(ring[wr_ptr]);
         wr_ptr       <= wr_ptr + 1'b1;
         if (fill != FULL) fill <= fill + 1'b1;
      end
   end

   assign avg       = sum[SW-1:AVG_LOG2];
   assign avg_valid = (fill == FULL);

endmodule

// File: rtl/sc_grid_monitor.sv
// Grid voltage/frequency monitor: averaging, hysteretic classification, debounce and fast fault trip.
//
// state         | meaning
// GRID_NORMAL   | both averages inside nominal bands (shrunk bands needed to re-enter)
// GRID_UNSTABLE | outside nominal but inside fault bands
// GRID_FAULT    | either average outside its fault band; also the reset/clear state
module sc_grid_monitor
   import sc_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   sc_grid_monitor_if.slave   bus
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [W-1:0]  v_avg, f_avg;
   logic          v_valid, f_valid, avg_valid;
   logic          valid_d1;
   grid_state_t   state, cand, cls;
   logic [CW-1:0] cnt, next_cnt;
   logic          chg;
   logic [7:0]    fcount;
   logic          cls_en;

   sc_moving_avg #(.W(W), .AVG_LOG2(AVG_LOG2)) u_v_avg (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (bus.monitor_clear),
      .sample_valid (bus.sample_valid),
      .sample       (bus.v_sample),
      .avg          (v_avg),
      .avg_valid    (v_valid)
   );

   sc_moving_avg #(.W(W), .AVG_LOG2(AVG_LOG2)) u_f_avg (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (bus.monitor_clear),
      .sample_valid (bus.sample_valid),
      .sample       (bus.f_sample),
      .avg          (f_avg),
      .avg_valid    (f_valid)
   );

   assign avg_valid = v_valid & f_valid;
   assign cls_en    = valid_d1 & avg_valid;

   always_comb begin
      cls = GRID_NORMAL;
      if (!in_band(v_avg, V_FLT_LO, V_FLT_HI) || !in_band(f_avg, F_FLT_LO, F_FLT_HI))
         cls = GRID_FAULT;
      else if (!in_band(v_avg, V_NOM_LO, V_NOM_HI) || !in_band(f_avg, F_NOM_LO, F_NOM_HI))
         cls = GRID_UNSTABLE;
      else if (state != GRID_NORMAL &&
               (!in_band(v_avg, V_NOM_LO + HYST, V_NOM_HI - HYST) ||
                !in_band(f_avg, F_NOM_LO + F_HYST, F_NOM_HI - F_HYST)))
         cls = GRID_UNSTABLE;
   end

   assign next_cnt = (cnt != '0 && cls == cand) ? cnt + 1'b1 : CW'(1);

   always_ff @(posedge clk) begin
      if (!reset_n || bus.monitor_clear) begin
         valid_d1 <= 1'b0;
         state    <= GRID_FAULT;
         cand     <= GRID_FAULT;
         cnt      <= '0;
         chg      <= 1'b0;
         if (!reset_n) fcount <= '0;
      end else begin
         valid_d1 <= bus.sample_valid;
         chg      <= 1'b0;
         if (cls_en) begin
            if (cls == state) begin
               cnt <= '0;
            end else if (cls == GRID_FAULT) begin
               state <= GRID_FAULT;
               chg   <= 1'b1;
               cnt   <= '0;
               if (fcount != 8'hFF) fcount <= fcount + 8'd1;
            end else if (next_cnt == CW'(DEBOUNCE)) begin
               state <= cls;
               chg   <= 1'b1;
               cnt   <= '0;
            end else begin
               cand <= cls;
               cnt  <= next_cnt;
            end
         end
      end
   end

   assign bus.grid_state   = state;
   assign bus.state_change = chg;
   assign bus.avg_valid    = avg_valid;
   assign bus.v_avg        = v_avg;
   assign bus.f_avg        = f_avg;
   assign bus.fault_count  = fcount;

endmodule

// File: tb/tb_sc_grid_monitor.sv
// Directed bench for the grid monitor with a small reference model of the averaging windows.
module tb_sc_grid_monitor;
   import sc_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sc_grid_monitor_if bus();

   sc_grid_monitor dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int ntests = 0;
   int nfail  = 0;
   int mv[8];
   int mf[8];
   int mptr  = 0;
   int mfill = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input grid_state_t exp, input logic exp_chg);
      chk(tag, 16'(bus.grid_state), 16'(exp));
      chk({tag, "_chg"}, 16'(bus.state_change), 16'(exp_chg));
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         mv[i] = 0;
         mf[i] = 0;
      end
      mptr  = 0;
      mfill = 0;
   endtask

   task automatic model_push(input int v, input int f);
      mv[mptr] = v;
      mf[mptr] = f;
      mptr = (mptr + 1) % 8;
      if (mfill < 8) mfill++;
   endtask

   task automatic check_avg(input string tag);
      int sv, sf;
      sv = 0;
      sf = 0;
      for (int i = 0; i < 8; i++) begin
         sv += mv[i];
         sf += mf[i];
      end
      chk({tag, "_avg_valid"}, 16'(bus.avg_valid), 16'(mfill == 8));
      chk({tag, "_v_avg"}, 16'(bus.v_avg), 16'(sv / 8));
      chk({tag, "_f_avg"}, 16'(bus.f_avg), 16'(sf / 8));
   endtask

   // One sample, then wait until its classification is visible.
   task automatic send(input int v, input int f);
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.v_sample     = 12'(v);
      bus.f_sample     = 12'(f);
      model_push(v, f);
      @(negedge clk);
      bus.sample_valid = 1'b0;
      @(negedge clk);
      check_avg("send");
   endtask

   task automatic chk_reset_values(input string tag);
      chk_state(tag, GRID_FAULT, 1'b0);
      chk({tag, "_avg_valid"}, 16'(bus.avg_valid), 16'd0);
      chk({tag, "_v_avg"}, 16'(bus.v_avg), 16'd0);
      chk({tag, "_f_avg"}, 16'(bus.f_avg), 16'd0);
   endtask

   initial begin
      bus.sample_valid  = 1'b0;
      bus.v_sample      = '0;
      bus.f_sample      = '0;
      bus.monitor_clear = 1'b0;
      model_clear();

      // Reset state
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_values("rst");
      chk("rst_fault_count", 16'(bus.fault_count), 16'd0);
      reset_n = 1'b1;

      // 1: 11 back-to-back nominal samples, cycle-accurate checks
      for (int c = 0; c <= 14; c++) begin
         if (c >= 1) begin
            chk("t1_avg_valid", 16'(bus.avg_valid), 16'(c >= 8));
            chk("t1_state", 16'(bus.grid_state), 16'((c >= 12) ? GRID_NORMAL : GRID_FAULT));
            chk("t1_chg", 16'(bus.state_change), 16'(c == 12));
         end
         if (c <= 10) begin
            bus.sample_valid = 1'b1;
            bus.v_sample     = 12'd3600;
            bus.f_sample     = 12'd2000;
            model_push(3600, 2000);
         end else begin
            bus.sample_valid = 1'b0;
         end
         @(negedge clk);
      end
      check_avg("t1");

      // 2: drift high to UNSTABLE, hysteresis hold, return to NORMAL
      for (int k = 1; k <= 10; k++) begin
         send(3850, 2000);
         if (k == 9) chk_state("t2_pre", GRID_NORMAL, 1'b0);
      end
      chk_state("t2_unst", GRID_UNSTABLE, 1'b1);
      for (int k = 1; k <= 12; k++) send(3790, 2000);
      chk_state("t2_hyst", GRID_UNSTABLE, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         send(3700, 2000);
         if (k == 3) chk_state("t2_ret_pre", GRID_UNSTABLE, 1'b0);
         if (k == 4) chk_state("t2_ret", GRID_NORMAL, 1'b1);
      end
      chk_state("t2_end", GRID_NORMAL, 1'b0);

      // 3: single frequency spike (avg 2055) trips FAULT immediately
      send(3700, 2440);
      chk_state("t3_trip", GRID_FAULT, 1'b1);
      chk("t3_fault_count", 16'(bus.fault_count), 16'd1);
      for (int s = 1; s <= 11; s++) begin
         send(3700, 2000);
         if (s == 10) chk_state("t3_hold", GRID_FAULT, 1'b0);
         if (s == 11) chk_state("t3_exit", GRID_NORMAL, 1'b1);
      end

      // 4: interrupted debounce (f_avg 2012 / 2000)
      send(3700, 2096);
      send(3700, 2000);
      send(3700, 2000);
      send(3700, 1904);
      chk_state("t4_break", GRID_NORMAL, 1'b0);
      send(3700, 2096);
      send(3700, 2000);
      send(3700, 2000);
      chk_state("t4_hold", GRID_NORMAL, 1'b0);
      send(3700, 2000);
      chk_state("t4_commit", GRID_UNSTABLE, 1'b1);
      chk("t4_fault_count", 16'(bus.fault_count), 16'd1);

      // 5: fault_count saturation over 300 episodes, then random window check
      for (int k = 0; k < 12; k++) send(3700, 2000);
      chk_state("t5_settle", GRID_NORMAL, 1'b0);
      for (int e = 0; e < 300; e++) begin
         repeat (8) send(3700, 2440);
         repeat (11) send(3700, 2000);
         chk_state("t5_episode", GRID_NORMAL, 1'b1);
         if (e == 99) chk("t5_fault_count_mid", 16'(bus.fault_count), 16'd101);
      end
      chk("t5_fault_count_sat", 16'(bus.fault_count), 16'd255);
      send(3700, 2440);
      chk_state("t5_trip_sat", GRID_FAULT, 1'b1);
      chk("t5_fault_count_hold", 16'(bus.fault_count), 16'd255);
      for (int k = 0; k < 1000; k++) send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      chk("t5_fault_count_rand", 16'(bus.fault_count), 16'd255);

      // 6: clear with a simultaneous sample, then reset mid-debounce
      for (int k = 0; k < 3; k++) send(3600, 2000);
      @(negedge clk);
      bus.sample_valid  = 1'b1;
      bus.monitor_clear = 1'b1;
      bus.v_sample      = 12'd1234;
      bus.f_sample      = 12'd1234;
      @(negedge clk);
      bus.sample_valid  = 1'b0;
      bus.monitor_clear = 1'b0;
      model_clear();
      chk_reset_values("t6_clr");
      chk("t6_clr_fault_count", 16'(bus.fault_count), 16'd255);
      for (int k = 0; k < 7; k++) send(3600, 2000);
      chk("t6_fill7", 16'(bus.avg_valid), 16'd0);
      send(3600, 2000);
      chk("t6_fill8", 16'(bus.avg_valid), 16'd1);
      send(3600, 2000);
      send(3600, 2000);
      chk_state("t6_mid_deb", GRID_FAULT, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk_reset_values("t6_rst");
      chk("t6_rst_fault_count", 16'(bus.fault_count), 16'd0);
      reset_n = 1'b1;
      model_clear();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/sc_grid_monitor.md
Name: sc_grid_monitor

Overview:
Upstream stage of sc_top. Converts raw grid voltage/frequency ADC samples into the debounced grid_state_t consumed by the charging FSM and safety monitor. Each channel goes through a moving average, then threshold classification with hysteresis and debounce. Entry to FAULT is a fast trip.

Parameters:
W, 12, sample width (unsigned codes)
AVG_LOG2, 3, log2 of averaging window (8 samples)
DEBOUNCE, 4, consecutive matching classifications required for a state change
V_NOM_LO / V_NOM_HI, 3400 / 3800, voltage nominal band (inclusive)
V_FLT_LO / V_FLT_HI, 3000 / 4100, voltage fault band (inclusive)
F_NOM_LO / F_NOM_HI, 1990 / 2010, frequency nominal band
F_FLT_LO / F_FLT_HI, 1950 / 2050, frequency fault band
HYST, 20, band shrink on each side for return to NORMAL

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
sample_valid  in  1  v_sample/f_sample valid this cycle; may be high every cycle
v_sample  in  W  grid voltage code
f_sample  in  W  grid frequency code
monitor_clear  in  1  synchronous flush of window and state
grid_state  out  grid_state_t  debounced grid classification
state_change  out  1  one-cycle pulse when grid_state changes
avg_valid  out  1  window filled; averages meaningful
v_avg  out  W  voltage average
f_avg  out  W  frequency average
fault_count  out  8  saturating count of FAULT entries

Behaviour:
- Reset (reset_n=0 at clk edge) or monitor_clear=1: clear ring buffers, sums and fill counter. grid_state=GRID_FAULT, state_change=0, avg_valid=0, v_avg=f_avg=0, debounce counter=0. fault_count is cleared only by reset, not by monitor_clear. monitor_clear has priority over sample_valid in the same cycle.
- Averaging: 2^AVG_LOG2-entry ring per channel. On sample_valid the new sample is written and running sum updated: sum += new − oldest. Oldest is 0 until filled. Sum width is W+AVG_LOG2 and never overflows. avg = sum >> AVG_LOG2 (truncating).
- Fill counter saturates at 2^AVG_LOG2. avg_valid rises one clock after the 2^AVG_LOG2-th accepted sample. Write pointer wraps modulo 2^AVG_LOG2.
- Classification, evaluated on each sample_valid once avg_valid is set, one clock after the sum update:
  - FAULT if either average is outside its fault band.
  - Else UNSTABLE if either average is outside its nominal band.
  - Else NORMAL. While grid_state≠NORMAL, NORMAL additionally requires both averages within [NOM_LO+HYST, NOM_HI−HYST]. Averages inside the nominal band but outside the shrunk band classify as UNSTABLE.
- Latency: grid_state reflects a sample 2 clocks after its sample_valid cycle (stage 1 sum, stage 2 classify/commit).
- Debounce:
  - A classification equal to grid_state resets the candidate counter.
  - A different classification equal to the current candidate increments the counter. When the count reaches DEBOUNCE, grid_state takes the candidate and the counter clears.
  - A differing classification that does not match the candidate restarts the count at 1 with the new candidate.
  - No counting on cycles without sample_valid; the count is held.
- Fast trip: a FAULT classification while grid_state≠FAULT commits immediately, bypassing debounce. Leaving FAULT uses normal debounce.
- state_change pulses in the cycle grid_state takes its new value. It is never asserted on reset or clear.
- fault_count increments on each transition into FAULT and saturates at 255.

Decomposition:
- sc_pkg holds:
  - grid_state_t: 2-bit enum, GRID_NORMAL=0, GRID_UNSTABLE=1, GRID_FAULT=2.
  - Shared width constants.
- Sub-module sc_moving_avg (ring, running sum, fill counter, avg_valid), parameterised by W and AVG_LOG2 and instantiated once per channel. Classification, hysteresis and debounce stay in sc_grid_monitor.

Test Plan:
1. Reset, then 8 samples v=3600,f=2000 back-to-back → avg_valid=1 one clock after the 8th sample; grid_state stays FAULT until 4 classifications; NORMAL 2 clocks after the 11th sample, with a single state_change pulse.
2. From NORMAL, feed v=3850 ×8 (avg leaves nominal) → UNSTABLE after 4 classifications once avg>3800. Then feed v=3790 → stays UNSTABLE (above 3780). Then feed v=3700 → NORMAL after debounce.
3. From NORMAL, a single burst driving v_avg to 4150 → FAULT on the first such classification, no debounce; fault_count increments by 1.
4. Debounce interruption: 3 UNSTABLE classifications, 1 NORMAL, 3 UNSTABLE → grid_state remains NORMAL; the 4th consecutive UNSTABLE commits.
5. Wrap/saturation: 300 alternating fault/normal episodes → fault_count=255 and holds. Ring pointer wraps over more than 1000 samples; v_avg equals the exact mean of the last 8 samples against the reference model.
6. monitor_clear asserted mid-window with sample_valid=1 → sample dropped, avg_valid=0, grid_state=FAULT, fault_count unchanged. reset_n=0 mid-debounce → all outputs return to reset values the next clock.
